// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared types and constants for the scoreboarded register file
package regfile_sb_pkg;

    localparam int rvga_num_regs    = 32;
    localparam int pend_cnt_width_d = 2;

    typedef logic [4:0]                  rvga_reg;
    typedef logic [31:0]                 rvga_word;
    typedef logic [pend_cnt_width_d-1:0] rvga_pend_cnt;

    // Largest number of in-flight writers a counter of the given width can track.
    function automatic int unsigned pend_cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback bus into the scoreboarded register file
interface regfile_sb_if;
    import regfile_sb_pkg::*;

    // decode read side
    rvga_reg  rs1_i;
    logic     rs1_v_i;
    rvga_reg  rs2_i;
    logic     rs2_v_i;
    rvga_word rs1_data_o;
    rvga_word rs2_data_o;

    // decode issue side
    logic     issue_v_i;
    rvga_reg  issue_rd_i;
    logic     issue_rd_w_v_i;
    logic     hazard_v_o;

    // writeback side
    rvga_reg  rd_i;
    rvga_word rd_data_i;
    logic     rd_w_v_i;
    logic     flush_i;

    // status
    logic     underflow_o;

    modport slave (
        input  rs1_i, rs1_v_i, rs2_i, rs2_v_i,
        input  issue_v_i, issue_rd_i, issue_rd_w_v_i,
        input  rd_i, rd_data_i, rd_w_v_i, flush_i,
        output rs1_data_o, rs2_data_o, hazard_v_o, underflow_o
    );

    modport master (
        output rs1_i, rs1_v_i, rs2_i, rs2_v_i,
        output issue_v_i, issue_rd_i, issue_rd_w_v_i,
        output rd_i, rd_data_i, rd_w_v_i, flush_i,
        input  rs1_data_o, rs2_data_o, hazard_v_o, underflow_o
    );

endinterface

// File: rtl/regfile_sb_ctl.sv
// rtl/regfile_sb_ctl.sv - pending-write counters, hazard detection and underflow flag
module regfile_sb_ctl
    import regfile_sb_pkg::*;
#(
    parameter int pend_cnt_width_p = pend_cnt_width_d
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rvga_reg rs1_i,
    input  logic    rs1_v_i,
    input  rvga_reg rs2_i,
    input  logic    rs2_v_i,
    input  logic    issue_v_i,
    input  rvga_reg issue_rd_i,
    input  logic    issue_rd_w_v_i,
    input  rvga_reg rd_i,
    input  logic    rd_w_v_i,
    input  logic    flush_i,
    output logic    hazard_v_o,
    output logic    underflow_o
);

    typedef logic [pend_cnt_width_p-1:0] cnt_t;

    localparam cnt_t cnt_max = cnt_t'(pend_cnt_max(pend_cnt_width_p));

    cnt_t cnt [rvga_num_regs];

    // A writeback to x0 is architecturally a no-op and never touches the scoreboard.
    logic wb_v;
    assign wb_v = rd_w_v_i && (rd_i != '0);

    logic wb_rs1;
    logic wb_rs2;
    logic wb_issue;
    cnt_t floor_rs1;
    cnt_t floor_rs2;
    logic busy_rs1;
    logic busy_rs2;
    logic sat;
    logic hazard;
    logic acc;
    logic underflow_set;
    logic [rvga_num_regs-1:0] inc_vec;
    logic [rvga_num_regs-1:0] dec_vec;

    // Source busy unless the only outstanding writer is retiring now (bypass covers it).
    always_comb begin
        wb_rs1    = wb_v && (rd_i == rs1_i);
        wb_rs2    = wb_v && (rd_i == rs2_i);
        wb_issue  = wb_v && (rd_i == issue_rd_i);
        floor_rs1 = wb_rs1 ? cnt_t'(1) : '0;
        floor_rs2 = wb_rs2 ? cnt_t'(1) : '0;
        busy_rs1  = rs1_v_i && (rs1_i != '0) && (cnt[rs1_i] > floor_rs1);
        busy_rs2  = rs2_v_i && (rs2_i != '0) && (cnt[rs2_i] > floor_rs2);
        // A full counter may still accept a new writer if one retires in the same cycle.
        sat       = issue_v_i && issue_rd_w_v_i && (issue_rd_i != '0) &&
                    (cnt[issue_rd_i] == cnt_max) && !wb_issue;
        hazard    = issue_v_i && (busy_rs1 || busy_rs2 || sat);
        acc       = issue_v_i && !hazard && issue_rd_w_v_i && (issue_rd_i != '0);
        underflow_set = wb_v && (cnt[rd_i] == '0) && !flush_i;
    end

    // Per-register increment/decrement requests; bit 0 stays clear so x0 never counts.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < rvga_num_regs; i++) begin
            inc_vec[i] = acc && (issue_rd_i == rvga_reg'(i));
            dec_vec[i] = wb_v && (rd_i == rvga_reg'(i)) && (cnt[i] != '0);
        end
    end

    assign hazard_v_o = hazard;

    // Counter array: flush squashes everything, otherwise issue/retire net out per register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < rvga_num_regs; i++) begin
                cnt[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < rvga_num_regs; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < rvga_num_regs; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   cnt[i] <= cnt[i] + cnt_t'(1);
                    2'b01:   cnt[i] <= cnt[i] - cnt_t'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Sticky error: a writeback with no matching in-flight issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underflow_o <= 1'b0;
        end else if (underflow_set) begin
            underflow_o <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - architectural register file with bypassed reads and write scoreboard
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int pend_cnt_width_p = pend_cnt_width_d
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_sb_if.slave  bus
);

    rvga_word mem [rvga_num_regs];

    logic wr_en;
    assign wr_en = bus.rd_w_v_i && (bus.rd_i != '0);

    // Data array; writeback commits regardless of flush, x0 is never written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < rvga_num_regs; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.rd_i] <= bus.rd_data_i;
        end
    end

    // Read port 1: x0 is hardwired zero, same-cycle writeback data wins over the array.
    always_comb begin
        bus.rs1_data_o = mem[bus.rs1_i];
        if (bus.rs1_i == '0) begin
            bus.rs1_data_o = '0;
        end else if (bus.rd_w_v_i && (bus.rd_i == bus.rs1_i)) begin
            bus.rs1_data_o = bus.rd_data_i;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        bus.rs2_data_o = mem[bus.rs2_i];
        if (bus.rs2_i == '0) begin
            bus.rs2_data_o = '0;
        end else if (bus.rd_w_v_i && (bus.rd_i == bus.rs2_i)) begin
            bus.rs2_data_o = bus.rd_data_i;
        end
    end

    logic hazard;
    logic underflow;

    regfile_sb_ctl #(
        .pend_cnt_width_p (pend_cnt_width_p)
    ) u_ctl (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs1_i          (bus.rs1_i),
        .rs1_v_i        (bus.rs1_v_i),
        .rs2_i          (bus.rs2_i),
        .rs2_v_i        (bus.rs2_v_i),
        .issue_v_i      (bus.issue_v_i),
        .issue_rd_i     (bus.issue_rd_i),
        .issue_rd_w_v_i (bus.issue_rd_w_v_i),
        .rd_i           (bus.rd_i),
        .rd_w_v_i       (bus.rd_w_v_i),
        .flush_i        (bus.flush_i),
        .hazard_v_o     (hazard),
        .underflow_o    (underflow)
    );

    assign bus.hazard_v_o  = hazard;
    assign bus.underflow_o = underflow;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vectors plus randomized model comparison for regfile_sb
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_sb_if bus();

    regfile_sb #(.pend_cnt_width_p(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rs1;
        logic        rs1_v;
        logic [4:0]  rs2;
        logic        rs2_v;
        logic        issue_v;
        logic [4:0]  issue_rd;
        logic        issue_w;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        rd_w;
        logic        flush;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic        exp_haz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic rs1_v, input logic [4:0] rs2, input logic rs2_v,
        input logic issue_v, input logic [4:0] issue_rd, input logic issue_w,
        input logic [4:0] rd, input logic [31:0] rd_data, input logic rd_w, input logic flush,
        input logic [31:0] exp_rs1, input logic [31:0] exp_rs2, input logic exp_haz);
        vec_t v;
        v.rs1 = rs1; v.rs1_v = rs1_v; v.rs2 = rs2; v.rs2_v = rs2_v;
        v.issue_v = issue_v; v.issue_rd = issue_rd; v.issue_w = issue_w;
        v.rd = rd; v.rd_data = rd_data; v.rd_w = rd_w; v.flush = flush;
        v.exp_rs1 = exp_rs1; v.exp_rs2 = exp_rs2; v.exp_haz = exp_haz;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.rs1_i = v.rs1; bus.rs1_v_i = v.rs1_v;
        bus.rs2_i = v.rs2; bus.rs2_v_i = v.rs2_v;
        bus.issue_v_i = v.issue_v; bus.issue_rd_i = v.issue_rd; bus.issue_rd_w_v_i = v.issue_w;
        bus.rd_i = v.rd; bus.rd_data_i = v.rd_data; bus.rd_w_v_i = v.rd_w;
        bus.flush_i = v.flush;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Reference model: register values, in-flight writer counts, sticky error.
    logic [31:0] mem_m [32];
    int          cnt_m [32];
    logic        uf_m;
    localparam int max_m = 3;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_m[i] = 0;
            cnt_m[i] = 0;
        end
        uf_m = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] r);
        if (r == 0) return 0;
        if (v.rd_w && v.rd == r) return v.rd_data;
        return mem_m[r];
    endfunction

    function automatic logic m_busy(input vec_t v, input logic use_v, input logic [4:0] r);
        int retiring;
        retiring = (v.rd_w && v.rd == r) ? 1 : 0;
        return use_v && r != 0 && cnt_m[r] > retiring;
    endfunction

    function automatic logic m_hazard(input vec_t v);
        logic full;
        full = v.issue_v && v.issue_w && v.issue_rd != 0 && cnt_m[v.issue_rd] == max_m &&
               !(v.rd_w && v.rd == v.issue_rd);
        return v.issue_v && (m_busy(v, v.rs1_v, v.rs1) || m_busy(v, v.rs2_v, v.rs2) || full);
    endfunction

    function automatic void model_step(input vec_t v, input logic haz);
        if (v.rd_w && v.rd != 0) mem_m[v.rd] = v.rd_data;
        if (v.flush) begin
            for (int i = 0; i < 32; i++) cnt_m[i] = 0;
        end else begin
            if (v.rd_w && v.rd != 0) begin
                if (cnt_m[v.rd] == 0) uf_m = 1'b1;
                else cnt_m[v.rd] = cnt_m[v.rd] - 1;
            end
            if (v.issue_v && !haz && v.issue_w && v.issue_rd != 0)
                cnt_m[v.issue_rd] = cnt_m[v.issue_rd] + 1;
        end
    endfunction

    // Asynchronous reset pulsed mid-cycle with live read/issue requests on the bus.
    task automatic reset_and_check(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        drive(mk(5, 1, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check({tag, "_rs1"}, bus.rs1_data_o, 0);
        check({tag, "_rs2"}, bus.rs2_data_o, 0);
        check({tag, "_haz"}, {31'd0, bus.hazard_v_o}, 0);
        check({tag, "_uf"},  {31'd0, bus.underflow_o}, 0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        model_reset();
    endtask

    vec_t v;
    logic haz_m;

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        reset_and_check("reset");

        // Directed vectors: read/write, bypass, x0, RAW hazard, saturation, flush.
        vecs.push_back(mk(5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7, 1, 0, 0, 0, 0, 0, 7, 32'h1234, 1, 0, 32'h1234, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 3, 32'hA5A5A5A5, 1, 0, 32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 4, 32'h44, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(4, 1, 0, 0, 0, 0, 0, 4, 32'h45 + k, 1, 0, 32'h45 + k, 0, 0));
        vecs.push_back(mk(4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h47, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8, 1, 0, 0, 0, 0, 0, 8, 32'h55, 1, 1, 32'h55, 0, 0));
        vecs.push_back(mk(8, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_rs1", i), bus.rs1_data_o, vecs[i].exp_rs1);
            check($sformatf("vec%0d_rs2", i), bus.rs2_data_o, vecs[i].exp_rs2);
            check($sformatf("vec%0d_haz", i), {31'd0, bus.hazard_v_o}, {31'd0, vecs[i].exp_haz});
            check($sformatf("vec%0d_uf", i), {31'd0, bus.underflow_o}, 0);
        end

        // Underflow: writeback to x10 with nothing in flight.
        @(negedge clk);
        drive(mk(10, 1, 0, 0, 0, 0, 0, 10, 32'hCAFEF00D, 1, 0, 0, 0, 0));
        #1;
        check("uf_same_cycle", {31'd0, bus.underflow_o}, 0);
        check("uf_bypass", bus.rs1_data_o, 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(mk(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            check($sformatf("uf_sticky%0d", k), {31'd0, bus.underflow_o}, 1);
            check($sformatf("uf_x10_%0d", k), bus.rs1_data_o, 32'hCAFEF00D);
        end
        reset_and_check("uf_clear");

        // Randomized traffic against the model, with one reset partway through.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) reset_and_check("mid_reset");
            @(negedge clk);
            v.rs1 = 5'($urandom_range(0, 7));  v.rs1_v = 1'($urandom_range(0, 1));
            v.rs2 = 5'($urandom_range(0, 7));  v.rs2_v = 1'($urandom_range(0, 1));
            v.issue_v  = ($urandom_range(0, 9) < 6);
            v.issue_rd = 5'($urandom_range(0, 7));
            v.issue_w  = ($urandom_range(0, 3) != 0);
            v.rd       = 5'($urandom_range(0, 7));
            v.rd_data  = $urandom;
            if (v.rd != 0 && cnt_m[v.rd] > 0) v.rd_w = 1'($urandom_range(0, 1));
            else v.rd_w = ($urandom_range(0, 19) == 0);
            v.flush = ($urandom_range(0, 24) == 0);
            if (v.flush) v.issue_v = 1'b0;
            drive(v);
            #1;
            haz_m = m_hazard(v);
            check($sformatf("rnd%0d_rs1", c), bus.rs1_data_o, m_read(v, v.rs1));
            check($sformatf("rnd%0d_rs2", c), bus.rs2_data_o, m_read(v, v.rs2));
            check($sformatf("rnd%0d_haz", c), {31'd0, bus.hazard_v_o}, {31'd0, haz_m});
            check($sformatf("rnd%0d_uf", c), {31'd0, bus.underflow_o}, {31'd0, uf_m});
            @(posedge clk);
            model_step(v, haz_m);
        end

        @(negedge clk);
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
